// File: rtl/x8_display_pkg.sv
// x8_display_pkg
// Shared definitions for the eight-digit seven-segment sequencer:
// FSM state encoding, digit geometry, radix limits and the active-low
// segment patterns (bit order a..g, MSB to LSB).
package x8_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int         NUM_DIGITS = 7;
    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

    localparam logic [4:0] RADIX_MIN = 5'd2;
    localparam logic [4:0] RADIX_MAX = 5'd16;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // Element n is the pattern for hex digit n (listed F down to 0).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b1110010,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    localparam logic [55:0] SEGS_RESET = {56{1'b1}};
    localparam logic [55:0] SEGS_ERROR = {SEG_BLANK, {NUM_DIGITS{SEG_DASH}}};

endpackage

// File: rtl/seq_divider.sv
// seq_divider
// Restoring divider, 32-bit dividend by 5-bit divisor, one quotient bit
// per step. After the last step of a division it reloads its own quotient
// as the next dividend, so successive radix digits come out back-to-back.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               load dividend/divisor, bit counter 31
//   step                perform one restoring step
//   dividend, divisor   operands sampled on start (divisor must be 2..16)
//   quotient            quotient after the current step (combinational)
//   remainder           partial remainder after the current step
//   last                current step is the 32nd of this division
module seq_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [4:0]  divisor,
    output logic [31:0] quotient,
    output logic [3:0]  remainder,
    output logic        last
);

    logic [31:0] q_reg;
    logic [3:0]  r_reg;
    logic [4:0]  d_reg;
    logic [4:0]  cnt_reg;

    logic [4:0] trial;
    logic [4:0] diff;
    logic       fits;

    // Partial remainder is below the divisor (<=16), so it fits 4 bits;
    // the shifted trial value needs 5.
    assign trial     = {r_reg, q_reg[31]};
    assign fits      = (trial >= d_reg);
    assign diff      = trial - d_reg;
    assign quotient  = {q_reg[30:0], fits};
    assign remainder = fits ? diff[3:0] : trial[3:0];
    assign last      = (cnt_reg == 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg   <= '0;
            r_reg   <= '0;
            d_reg   <= '0;
            cnt_reg <= '0;
        end else if (start) begin
            q_reg   <= dividend;
            r_reg   <= '0;
            d_reg   <= divisor;
            cnt_reg <= 5'd31;
        end else if (step) begin
            q_reg <= quotient;
            if (last) begin
                r_reg   <= '0;
                cnt_reg <= 5'd31;
            end else begin
                r_reg   <= remainder;
                cnt_reg <= cnt_reg - 5'd1;
            end
        end
    end

endmodule

// File: rtl/x8_segment_sequencer.sv
// x8_segment_sequencer
// Converts a signed 32-bit value into an active-low 56-bit word for eight
// seven-segment digits (sign + seven magnitude digits) in radix 2..16,
// using one shared sequential divider for all digits.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   num, radix   value and base, sampled when load is accepted
//   load, ready  start handshake (accepted on load & ready)
//   done         one-cycle pulse after the result is committed
//   ovf          magnitude did not fit in seven digits
//   err          accepted radix was outside 2..16
//   segs         registered display word, digit 0 in segs[6:0]
// Parameter BLANK_LZ: 1 blanks leading-zero digits (digit 0 always shown).
module x8_segment_sequencer
    import x8_display_pkg::*;
#(
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] num,
    input  logic [4:0]  radix,
    input  logic        load,
    output logic        ready,
    output logic        done,
    output logic        ovf,
    output logic        err,
    output logic [55:0] segs
);

    state_t      state_reg;
    logic        ready_reg;
    logic        done_reg;
    logic        ovf_reg;
    logic        err_reg;
    logic [55:0] segs_reg;
    logic        neg_reg;
    logic [2:0]  k_reg;
    logic        err_pend_reg;
    logic        ovf_pend_reg;

    logic        radix_ok;
    logic [31:0] mag;
    logic        div_start;
    logic        div_step;
    logic [31:0] div_quotient;
    logic [3:0]  div_remainder;
    logic        div_last;

    logic [NUM_DIGITS-1:0] is_zero;
    logic [55:0]           segs_next;

    assign radix_ok  = (radix >= RADIX_MIN) && (radix <= RADIX_MAX);
    // 0x80000000 negates to itself, which reads correctly as unsigned.
    assign mag       = num[31] ? (~num + 32'd1) : num;
    assign div_start = (state_reg == ST_IDLE) && load && radix_ok;
    assign div_step  = (state_reg == ST_DIV);

    seq_divider u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .step      (div_step),
        .dividend  (mag),
        .divisor   (radix),
        .quotient  (div_quotient),
        .remainder (div_remainder),
        .last      (div_last)
    );

    // Digit register file and per-digit display pattern.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [3:0] value_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                value_reg <= '0;
            end else if (div_step && div_last && (k_reg == 3'(gi))) begin
                value_reg <= div_remainder;
            end
        end

        assign is_zero[gi] = (value_reg == 4'd0);

        if (gi == 0) begin : g_lsd
            assign segs_next[6:0] = SEG_TABLE[value_reg];
        end else begin : g_upper
            // Blank when this digit and every digit above it are zero.
            logic blank;
            assign blank = BLANK_LZ && (&is_zero[NUM_DIGITS-1:gi]);
            assign segs_next[gi*7 +: 7] = blank ? SEG_BLANK : SEG_TABLE[value_reg];
        end
    end

    // Sign digit: only segment g lights, and only for negative values.
    assign segs_next[55:49] = {6'b111111, ~neg_reg};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            ready_reg    <= 1'b1;
            done_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            err_reg      <= 1'b0;
            segs_reg     <= SEGS_RESET;
            neg_reg      <= 1'b0;
            k_reg        <= '0;
            err_pend_reg <= 1'b0;
            ovf_pend_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (load) begin
                        neg_reg      <= num[31];
                        k_reg        <= '0;
                        ovf_pend_reg <= 1'b0;
                        ready_reg    <= 1'b0;
                        err_pend_reg <= ~radix_ok;
                        state_reg    <= radix_ok ? ST_DIV : ST_COMMIT;
                    end
                end
                ST_DIV: begin
                    if (div_last) begin
                        if (k_reg == LAST_DIGIT) begin
                            // Whatever is left above seven digits means overflow.
                            ovf_pend_reg <= (div_quotient != 32'd0);
                            state_reg    <= ST_COMMIT;
                        end else begin
                            k_reg <= k_reg + 3'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    segs_reg  <= err_pend_reg ? SEGS_ERROR : segs_next;
                    ovf_reg   <= err_pend_reg ? 1'b0 : ovf_pend_reg;
                    err_reg   <= err_pend_reg;
                    done_reg  <= 1'b1;
                    ready_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign ready = ready_reg;
    assign done  = done_reg;
    assign ovf   = ovf_reg;
    assign err   = err_reg;
    assign segs  = segs_reg;

endmodule

// File: tb/tb_x8_segment_sequencer.sv
// tb_x8_segment_sequencer
// Drives two sequencer instances (leading zeros shown / blanked) with the
// same directed and random loads and compares against an arithmetic model.
module tb_x8_segment_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [31:0] num;
    logic [4:0]  radix;

    logic        ready0, done0, ovf0, err0;
    logic [55:0] segs0;
    logic        ready1, done1, ovf1, err1;
    logic [55:0] segs1;

    always #5 clk = ~clk;

    x8_segment_sequencer #(.BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .reset(reset), .num(num), .radix(radix), .load(load),
        .ready(ready0), .done(done0), .ovf(ovf0), .err(err0), .segs(segs0)
    );

    x8_segment_sequencer #(.BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .reset(reset), .num(num), .radix(radix), .load(load),
        .ready(ready1), .done(done1), .ovf(ovf1), .err(err1), .segs(segs1)
    );

    int total  = 0;
    int passed = 0;
    int failed = 0;

    logic [55:0] exp_segs0, exp_segs1;
    logic        exp_ovf, exp_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;   1: return 7'b1001111;
            2: return 7'b0010010;   3: return 7'b0000110;
            4: return 7'b1001100;   5: return 7'b0100100;
            6: return 7'b0100000;   7: return 7'b0001111;
            8: return 7'b0000000;   9: return 7'b0000100;
            10: return 7'b0001000;  11: return 7'b1100000;
            12: return 7'b1110010;  13: return 7'b1000010;
            14: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    // Reference: plain integer arithmetic on the magnitude.
    task automatic model(input logic [31:0] n, input logic [4:0] r,
                         output logic [55:0] s0, output logic [55:0] s1,
                         output logic o, output logic e);
        longint mag, rest, limit;
        int     d[7];
        int     msd;
        if (r < 2 || r > 16) begin
            s0 = {7'b1111111, {7{7'b1111110}}};
            s1 = s0;
            o  = 1'b0;
            e  = 1'b1;
            return;
        end
        mag   = n[31] ? (64'h1_0000_0000 - longint'({32'b0, n})) : longint'({32'b0, n});
        limit = 1;
        for (int i = 0; i < 7; i++) limit = limit * longint'(r);
        rest = mag;
        msd  = 0;
        for (int i = 0; i < 7; i++) begin
            d[i] = int'(rest % longint'(r));
            rest = rest / longint'(r);
            if (d[i] != 0) msd = i;
        end
        for (int i = 0; i < 7; i++) begin
            s0[i*7 +: 7] = seg_of(d[i]);
            s1[i*7 +: 7] = (i > msd) ? 7'b1111111 : seg_of(d[i]);
        end
        s0[55:49] = {6'b111111, ~n[31]};
        s1[55:49] = {6'b111111, ~n[31]};
        o = (mag >= limit);
        e = 1'b0;
    endtask

    // Called at #1 after an edge; ends at #1 after the edge that raised done.
    task automatic convert(input logic [31:0] n, input logic [4:0] r, input string tag);
        int cycles;
        int exp_lat;
        exp_lat = (r >= 2 && r <= 16) ? 225 : 1;
        num   = n;
        radix = r;
        load  = 1'b1;
        check({tag, "_ready_before"}, ready0, 1);
        tick();
        load  = 1'b0;
        num   = $urandom;
        radix = 5'($urandom);
        check({tag, "_busy"}, ready0, 0);
        check({tag, "_hold0"}, segs0, exp_segs0);
        check({tag, "_hold1"}, segs1, exp_segs1);
        cycles = 0;
        while (done0 !== 1'b1 && cycles < 400) begin
            tick();
            cycles++;
        end
        model(n, r, exp_segs0, exp_segs1, exp_ovf, exp_err);
        check({tag, "_latency"}, cycles, exp_lat);
        check({tag, "_segs0"}, segs0, exp_segs0);
        check({tag, "_segs1"}, segs1, exp_segs1);
        check({tag, "_ovf"}, {ovf1, ovf0}, {exp_ovf, exp_ovf});
        check({tag, "_err"}, {err1, err0}, {exp_err, exp_err});
        check({tag, "_done1"}, done1, 1);
        check({tag, "_ready_done"}, ready0, 1);
        $display("load num=%h radix=%0d latency=%0d segs0=%h segs1=%h ovf=%b err=%b",
                 n, r, cycles, segs0, segs1, ovf0, err0);
    endtask

    task automatic pulse_end(input string tag);
        tick();
        check({tag, "_done_pulse"}, done0, 0);
    endtask

    logic [55:0] want;
    logic [31:0] rnum;
    logic [4:0]  rrad;

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        num   = '0;
        radix = '0;
        exp_segs0 = '1;
        exp_segs1 = '1;
        exp_ovf   = 1'b0;
        exp_err   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_segs0", segs0, 56'hFF_FFFF_FFFF_FFFF);
        check("rst_segs1", segs1, 56'hFF_FFFF_FFFF_FFFF);
        check("rst_ready", {ready1, ready0}, 2'b11);
        check("rst_done", {done1, done0}, 2'b00);
        check("rst_ovf", {ovf1, ovf0}, 2'b00);
        check("rst_err", {err1, err0}, 2'b00);
        tick();

        // -1234 decimal
        convert(32'hFFFFFB2E, 5'd10, "neg1234");
        want = {7'b1111110, 7'b0000001, 7'b0000001, 7'b0000001,
                7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
        check("neg1234_literal", segs0, want);
        pulse_end("neg1234");

        convert(32'h7FFFFFFF, 5'd16, "maxhex");
        check("maxhex_ovf_lit", ovf0, 1);
        pulse_end("maxhex");

        convert(32'd5, 5'd10, "five");
        want = {7'b1111111, {6{7'b1111111}}, 7'b0100100};
        check("five_blank_literal", segs1, want);
        pulse_end("five");

        convert(32'h80000000, 5'd10, "minint");
        pulse_end("minint");

        convert(32'd77, 5'd1, "radix1");
        pulse_end("radix1");
        convert(32'd77, 5'd17, "radix17");
        check("radix17_err_lit", err0, 1);
        pulse_end("radix17");
        convert(32'd77, 5'd10, "err_clear");
        check("err_clear_lit", err0, 0);

        // Back-to-back: load in the done cycle itself.
        convert(32'hFFFFFFFF, 5'd2, "b2b");
        pulse_end("b2b");

        // Ignored load while busy, then reset mid-conversion.
        num = 32'd42; radix = 5'd10; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 1; i < 100; i++) tick();
        num = 32'd999; radix = 5'd7; load = 1'b1;
        tick();
        load = 1'b0;
        check("busy_load_ready", ready0, 0);
        check("busy_load_done", done0, 0);
        check("busy_hold", segs0, exp_segs0);
        for (int i = 101; i < 120; i++) tick();
        reset = 1'b1; load = 1'b1; num = 32'd7; radix = 5'd10;
        tick();
        reset = 1'b0; load = 1'b0;
        check("midrst_segs0", segs0, 56'hFF_FFFF_FFFF_FFFF);
        check("midrst_segs1", segs1, 56'hFF_FFFF_FFFF_FFFF);
        check("midrst_ready", ready0, 1);
        check("midrst_flags", {done0, ovf0, err0}, 3'b000);
        tick();
        check("midrst_no_accept", ready0, 1);
        exp_segs0 = '1; exp_segs1 = '1; exp_ovf = 1'b0; exp_err = 1'b0;
        convert(32'd42, 5'd10, "fresh");
        pulse_end("fresh");

        // Random loads.
        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 3))
                0: rnum = $urandom_range(0, 5000);
                1: rnum = -$urandom_range(0, 5000);
                default: rnum = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) rrad = 5'($urandom_range(0, 1) == 0 ? $urandom_range(0, 1) : $urandom_range(17, 31));
            else rrad = 5'($urandom_range(2, 16));
            convert(rnum, rrad, $sformatf("rand%0d", t));
            if ($urandom_range(0, 1) == 0) pulse_end($sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
